// File: rtl/vector_dram_arbiter_if.sv
// Bundle of the LSU, DMA and RAM-side signals of the vector data RAM arbiter.
// master = requesters plus RAM model, slave = arbiter.
interface vector_dram_arbiter_if;
  // Handshakes: lsu_req holds a beat until lsu_gnt; dma_req holds a burst until dma_ack;
  // dma_beat marks the cycle dma_wdata is consumed; *_rvalid is a one-cycle, unstallable strobe.
  logic          lsu_req;
  logic          lsu_we;
  logic [0:31]   lsu_addr;
  logic [0:127]  lsu_wdata;
  logic [0:15]   lsu_be;
  logic          lsu_gnt;
  logic          lsu_rvalid;
  logic [0:127]  lsu_rdata;
  logic          dma_req;
  logic          dma_we;
  logic [0:31]   dma_addr;
  logic [0:3]    dma_len;
  logic          dma_ack;
  logic          dma_busy;
  logic          dma_beat;
  logic [0:127]  dma_wdata;
  logic          dma_rvalid;
  logic [0:127]  dma_rdata;
  logic          dma_done;
  logic          mem_cs;
  logic          mem_rw;
  logic [0:31]   mem_addr;
  logic [0:127]  mem_wdata;
  logic [0:15]   mem_we;
  logic [0:127]  mem_rdata;
  logic          dbg_state;

  modport master (
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_ack, dma_busy, dma_beat, dma_rvalid, dma_rdata, dma_done,
    input  mem_cs, mem_rw, mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  dbg_state
  );

  modport slave (
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_ack, dma_busy, dma_beat, dma_rvalid, dma_rdata, dma_done,
    output mem_cs, mem_rw, mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output dbg_state
  );
endinterface

// File: rtl/vector_dram_arbiter.sv
// Arbitrates the single-port 128-bit vector RAM between LSU single beats and DMA bursts,
// with bounded LSU pre-emption of an active burst and owner-tagged 1-cycle read return.
module vector_dram_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input logic             clk,
  input logic             rst_b,
  vector_dram_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

  state_t            state_q, state_d;
  logic [0:31]       base_q;
  logic [3:0]        len_q;
  logic              dir_we_q;
  logic [3:0]        beat_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              done_q;
  logic              lsu_rd_q;
  logic              dma_rd_q;

  logic              lsu_win;
  logic              last_beat;
  logic              lsu_gnt;
  logic              dma_beat;
  logic              dma_ack;
  logic [0:31]       dma_cur_addr;

  assign lsu_win      = bus.lsu_req && (wait_cnt_q < WAIT_W'(MAX_WAIT));
  assign last_beat    = (beat_cnt_q == len_q);
  assign dma_cur_addr = base_q + {24'b0, beat_cnt_q, 4'b0};

  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.dma_req) state_d = BURST;
      BURST:   if (dma_beat && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The accept cycle never carries a DMA beat, so the LSU owns the RAM whenever IDLE.
  always_comb begin
    lsu_gnt  = 1'b0;
    dma_beat = 1'b0;
    dma_ack  = 1'b0;
    case (state_q)
      IDLE: begin
        lsu_gnt = bus.lsu_req;
        dma_ack = bus.dma_req;
      end
      BURST: begin
        lsu_gnt  = lsu_win;
        dma_beat = !lsu_win;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.mem_cs    = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = '0;
    if (lsu_gnt) begin
      bus.mem_cs    = 1'b1;
      bus.mem_rw    = !bus.lsu_we;
      bus.mem_addr  = bus.lsu_addr & LINE_MASK;
      bus.mem_wdata = bus.lsu_wdata;
      bus.mem_we    = bus.lsu_we ? bus.lsu_be : 16'h0000;
    end else if (dma_beat) begin
      bus.mem_cs    = 1'b1;
      bus.mem_rw    = !dir_we_q;
      bus.mem_addr  = dma_cur_addr;
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_we    = dir_we_q ? 16'hFFFF : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      base_q     <= '0;
      len_q      <= '0;
      dir_we_q   <= 1'b0;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      done_q     <= 1'b0;
      lsu_rd_q   <= 1'b0;
      dma_rd_q   <= 1'b0;
    end else begin
      done_q   <= dma_beat && last_beat;
      lsu_rd_q <= lsu_gnt && !bus.lsu_we;
      dma_rd_q <= dma_beat && !dir_we_q;
      if (dma_ack) begin
        base_q     <= bus.dma_addr & LINE_MASK;
        len_q      <= bus.dma_len;
        dir_we_q   <= bus.dma_we;
        beat_cnt_q <= '0;
        wait_cnt_q <= '0;
      end else if (state_q == BURST) begin
        if (lsu_win) begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end else begin
          wait_cnt_q <= '0;
          beat_cnt_q <= beat_cnt_q + 4'd1;
        end
      end
    end
  end

  assign bus.lsu_gnt    = lsu_gnt;
  assign bus.dma_beat   = dma_beat;
  assign bus.dma_ack    = dma_ack;
  assign bus.dma_busy   = (state_q == BURST);
  assign bus.dma_done   = done_q;
  assign bus.lsu_rvalid = lsu_rd_q;
  assign bus.dma_rvalid = dma_rd_q;
  assign bus.lsu_rdata  = lsu_rd_q ? bus.mem_rdata : '0;
  assign bus.dma_rdata  = dma_rd_q ? bus.mem_rdata : '0;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_vector_dram_arbiter.sv
// Bench for vector_dram_arbiter: LSU vector table, DMA burst sequences, read-return scoreboard.
module tb_vector_dram_arbiter;

  logic clk = 1'b0;
  logic rst_b = 1'b0;

  vector_dram_arbiter_if bus ();

  vector_dram_arbiter #(.MAX_WAIT(4), .WAIT_W(4)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [128:0] exp_q[$];   // {owner: 1=DMA, data}

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
  endfunction

  // RAM model: registered read data, junk when no read was issued.
  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_rw) bus.mem_rdata <= pat(bus.mem_addr);
    else                          bus.mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rd();
    logic [128:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e[128]) begin
        chk("dma_rvalid", 128'(bus.dma_rvalid), 128'd1);
        chk("dma_rdata", bus.dma_rdata, e[127:0]);
        chk("lsu_rvalid_off", 128'(bus.lsu_rvalid), 128'd0);
        chk("lsu_rdata_zero", bus.lsu_rdata, 128'd0);
      end else begin
        chk("lsu_rvalid", 128'(bus.lsu_rvalid), 128'd1);
        chk("lsu_rdata", bus.lsu_rdata, e[127:0]);
        chk("dma_rvalid_off", 128'(bus.dma_rvalid), 128'd0);
        chk("dma_rdata_zero", bus.dma_rdata, 128'd0);
      end
    end else begin
      chk("lsu_rvalid_none", 128'(bus.lsu_rvalid), 128'd0);
      chk("dma_rvalid_none", 128'(bus.dma_rvalid), 128'd0);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_rd();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lsu_req   = 1'b0;
    bus.lsu_we    = 1'b0;
    bus.lsu_addr  = '0;
    bus.lsu_wdata = '0;
    bus.lsu_be    = '0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_len   = '0;
    bus.dma_wdata = '0;
  endtask

  task automatic dma_accept(input logic we, input logic [31:0] addr, input logic [3:0] len);
    bus.dma_req  = 1'b1;
    bus.dma_we   = we;
    bus.dma_addr = addr;
    bus.dma_len  = len;
    sample();
    chk("accept_ack", 128'(bus.dma_ack), 128'd1);
    chk("accept_no_beat", 128'(bus.dma_beat), 128'd0);
    chk("accept_busy", 128'(bus.dma_busy), 128'd0);
    advance();
    bus.dma_req = 1'b0;
  endtask

  task automatic dma_beat_chk(input logic we, input logic [31:0] addr);
    logic [127:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    bus.dma_wdata = wd;
    sample();
    chk("beat_dma_beat", 128'(bus.dma_beat), 128'd1);
    chk("beat_lsu_gnt", 128'(bus.lsu_gnt), 128'd0);
    chk("beat_ack_ignored", 128'(bus.dma_ack), 128'd0);
    chk("beat_busy", 128'(bus.dma_busy), 128'd1);
    chk("beat_cs", 128'(bus.mem_cs), 128'd1);
    chk("beat_addr", 128'(bus.mem_addr), 128'(addr));
    chk("beat_rw", 128'(bus.mem_rw), 128'(!we));
    chk("beat_we", 128'(bus.mem_we), we ? 128'hFFFF : 128'd0);
    if (we) chk("beat_wdata", bus.mem_wdata, wd);
    else    exp_q.push_back({1'b1, pat(addr)});
    advance();
  endtask

  task automatic dma_finish();
    sample();
    chk("done_pulse", 128'(bus.dma_done), 128'd1);
    chk("done_busy_low", 128'(bus.dma_busy), 128'd0);
    advance();
    sample();
    chk("done_cleared", 128'(bus.dma_done), 128'd0);
    advance();
  endtask

  typedef struct {
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [15:0]  be;
    logic [127:0] wdata;
    logic         exp_cs;
    logic         exp_rw;
    logic [15:0]  exp_we;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic is_dma;
    logic [31:0] a;
    idle_inputs();
    bus.mem_rdata = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h40,   16'h0000, 128'h0, 1'b1, 1'b1, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 32'h40,   16'h000F, {4{32'hCAFE_F00D}}, 1'b1, 1'b0, 16'h000F};
    vecs[2] = '{1'b0, 1'b1, 32'h80,   16'hFFFF, 128'h1, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 32'h1230, 16'h0000, 128'h0, 1'b1, 1'b1, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 32'h1240, 16'h0000, 128'h0, 1'b1, 1'b1, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 32'h7770, 16'hFFFF, {4{32'h0BAD_BEEF}}, 1'b1, 1'b0, 16'hFFFF};
    for (int i = 6; i < 8; i++) begin
      vecs[i].req    = 1'b1;
      vecs[i].we     = 1'($urandom_range(0, 1));
      vecs[i].addr   = $urandom & 32'hFFFF_FFF0;
      vecs[i].be     = 16'($urandom);
      vecs[i].wdata  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].exp_cs = 1'b1;
      vecs[i].exp_rw = !vecs[i].we;
      vecs[i].exp_we = vecs[i].we ? vecs[i].be : 16'h0000;
    end

    // Reset state
    repeat (2) @(posedge clk);
    sample();
    chk("rst_busy", 128'(bus.dma_busy), 128'd0);
    chk("rst_done", 128'(bus.dma_done), 128'd0);
    chk("rst_state", 128'(bus.dbg_state), 128'd0);
    chk("rst_cs", 128'(bus.mem_cs), 128'd0);
    advance();
    rst_b = 1'b1;

    // LSU single beats while no burst is active
    for (int i = 0; i < 8; i++) begin
      bus.lsu_req   = vecs[i].req;
      bus.lsu_we    = vecs[i].we;
      bus.lsu_addr  = vecs[i].addr;
      bus.lsu_be    = vecs[i].be;
      bus.lsu_wdata = vecs[i].wdata;
      sample();
      chk("vec_gnt", 128'(bus.lsu_gnt), 128'(vecs[i].req));
      chk("vec_beat", 128'(bus.dma_beat), 128'd0);
      chk("vec_cs", 128'(bus.mem_cs), 128'(vecs[i].exp_cs));
      chk("vec_rw", 128'(bus.mem_rw), 128'(vecs[i].exp_rw));
      chk("vec_we", 128'(bus.mem_we), 128'(vecs[i].exp_we));
      chk("vec_addr", 128'(bus.mem_addr), vecs[i].req ? 128'(vecs[i].addr) : 128'd0);
      if (vecs[i].req && vecs[i].we) chk("vec_wdata", bus.mem_wdata, vecs[i].wdata);
      if (!vecs[i].req) chk("vec_wdata_zero", bus.mem_wdata, 128'd0);
      if (vecs[i].req && !vecs[i].we) exp_q.push_back({1'b0, pat(vecs[i].addr)});
      advance();
    end
    idle_inputs();

    // DMA write burst of 4 beats
    dma_accept(1'b1, 32'h100, 4'd3);
    for (int i = 0; i < 4; i++) dma_beat_chk(1'b1, 32'h100 + 32'(16 * i));
    dma_finish();

    // Starvation bound: LSU reads held high across a 2-beat DMA read burst
    dma_accept(1'b0, 32'h300, 4'd1);
    bus.lsu_req = 1'b1;
    bus.lsu_we  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = 32'h1000 + 32'(16 * i);
      bus.lsu_addr = a;
      is_dma = (i == 4) || (i == 9);
      sample();
      chk("starve_gnt", 128'(bus.lsu_gnt), 128'(!is_dma));
      chk("starve_beat", 128'(bus.dma_beat), 128'(is_dma));
      if (is_dma) begin
        a = (i == 9) ? 32'h310 : 32'h300;
        exp_q.push_back({1'b1, pat(a)});
      end else begin
        exp_q.push_back({1'b0, pat(a)});
      end
      chk("starve_addr", 128'(bus.mem_addr), 128'(a));
      advance();
    end
    bus.lsu_addr = 32'h2000;
    sample();
    chk("starve_done", 128'(bus.dma_done), 128'd1);
    chk("starve_idle_gnt", 128'(bus.lsu_gnt), 128'd1);
    exp_q.push_back({1'b0, pat(32'h2000)});
    advance();
    idle_inputs();
    sample();
    chk("starve_done_clr", 128'(bus.dma_done), 128'd0);
    advance();

    // Address wrap-around and forced line alignment
    dma_accept(1'b0, 32'hFFFF_FFF0, 4'd1);
    dma_beat_chk(1'b0, 32'hFFFF_FFF0);
    dma_beat_chk(1'b0, 32'h0000_0000);
    dma_finish();
    dma_accept(1'b1, 32'h205, 4'd0);
    dma_beat_chk(1'b1, 32'h200);
    dma_finish();

    // Reset on the second beat of an 8-beat read burst
    dma_accept(1'b0, 32'h400, 4'd7);
    dma_beat_chk(1'b0, 32'h400);
    rst_b = 1'b0;
    sample();
    chk("rst_mid_beat", 128'(bus.dma_beat), 128'd1);
    chk("rst_mid_addr", 128'(bus.mem_addr), 128'h410);
    advance();
    sample();
    chk("rst_mid_busy", 128'(bus.dma_busy), 128'd0);
    chk("rst_mid_done", 128'(bus.dma_done), 128'd0);
    chk("rst_mid_state", 128'(bus.dbg_state), 128'd0);
    advance();
    rst_b = 1'b1;
    sample();
    chk("rst_after_done", 128'(bus.dma_done), 128'd0);
    chk("rst_after_busy", 128'(bus.dma_busy), 128'd0);
    advance();
    dma_accept(1'b1, 32'h800, 4'd0);
    dma_beat_chk(1'b1, 32'h800);
    dma_finish();

    // dma_req held across the done cycle: ack and done coincide
    bus.dma_req  = 1'b1;
    bus.dma_we   = 1'b1;
    bus.dma_addr = 32'h500;
    bus.dma_len  = 4'd1;
    sample();
    chk("hold_ack", 128'(bus.dma_ack), 128'd1);
    advance();
    dma_beat_chk(1'b1, 32'h500);
    dma_beat_chk(1'b1, 32'h510);
    bus.dma_addr = 32'h600;
    bus.dma_len  = 4'd0;
    sample();
    chk("hold_done", 128'(bus.dma_done), 128'd1);
    chk("hold_ack_done", 128'(bus.dma_ack), 128'd1);
    advance();
    bus.dma_req = 1'b0;
    dma_beat_chk(1'b1, 32'h600);
    dma_finish();

    chk("exp_q_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
